multicycle_control: RTL

//  Main control FSM for the multicycle datapath; produces the 3-bit ALUop consumed by ALUcontrol

---
 rtl/ctrl_pkg.sv | 90 +++++++++
 rtl/ctrl_word_decode.sv | 96 +++++++++
 rtl/multicycle_control.sv | 92 +++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared control encodings for the multicycle datapath: opcodes, ALUop codes, FSM states and mux selects.
// MC_JAL_EN adds the jal opcode, its state and the $31 / PC write-back selects.
package ctrl_pkg;

    localparam int STATE_W = 4;
    localparam int ALUOP_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_JAL_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_ANDI  = 3'b100;

    localparam logic [1:0] REGDST_RT       = 2'b00;
    localparam logic [1:0] REGDST_RD       = 2'b01;
    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
`ifdef MC_JAL_EN
    localparam logic [1:0] REGDST_RA       = 2'b10;
    localparam logic [1:0] MEMTOREG_PC     = 2'b10;
`endif
    localparam logic [1:0] SRCB_RT         = 2'b00;
    localparam logic [1:0] SRCB_FOUR       = 2'b01;
    localparam logic [1:0] SRCB_IMM        = 2'b10;
    localparam logic [1:0] SRCB_IMMSH      = 2'b11;
    localparam logic [1:0] PCSRC_ALU       = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
`ifdef MC_JAL_EN
        ,S_JAL   = 4'd12
`endif
    } state_t;

    typedef struct packed {
        logic               pcWrite;
        logic               pcWriteCond;
        logic               branchNe;
        logic               iorD;
        logic               memRead;
        logic               memWrite;
        logic               irWrite;
        logic [1:0]         regDst;
        logic [1:0]         memtoReg;
        logic               regWrite;
        logic               aluSrcA;
        logic [1:0]         aluSrcB;
        logic [1:0]         pcSource;
        logic [ALUOP_W-1:0] aluOp;
        logic               illegalOp;
    } ctrl_word_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
`ifdef MC_JAL_EN
            OP_JAL:                        return 1'b1;
`endif
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// Combinational decode of the current FSM state (plus opcode / mem_ready where needed) into the control word.
// The JAL state decode exists only when MC_JAL_EN is defined.
module ctrl_word_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_word_t cw
);

    // Moore decode; only the FETCH strobes look at mem_ready so IR/PC load on the completing cycle.
    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.memRead  = 1'b1;
                cw.aluSrcB  = SRCB_FOUR;
                cw.aluOp    = ALUOP_ADD;
                cw.pcSource = PCSRC_ALU;
                cw.irWrite  = mem_ready;
                cw.pcWrite  = mem_ready;
            end
            S_DECODE: begin
                cw.aluSrcB   = SRCB_IMMSH;
                cw.aluOp     = ALUOP_ADD;
                cw.illegalOp = ~op_supported(opcode);
            end
            S_MEMADR: begin
                cw.aluSrcA = 1'b1;
                cw.aluSrcB = SRCB_IMM;
                cw.aluOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                cw.memRead = 1'b1;
                cw.iorD    = 1'b1;
            end
            S_MEMWB: begin
                cw.regDst   = REGDST_RT;
                cw.memtoReg = MEMTOREG_MDR;
                cw.regWrite = 1'b1;
            end
            S_MEMWR: begin
                cw.memWrite = 1'b1;
                cw.iorD     = 1'b1;
            end
            S_REX: begin
                cw.aluSrcA = 1'b1;
                cw.aluSrcB = SRCB_RT;
                cw.aluOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                cw.regDst   = REGDST_RD;
                cw.regWrite = 1'b1;
            end
            S_BRANCH: begin
                cw.aluSrcA     = 1'b1;
                cw.aluSrcB     = SRCB_RT;
                cw.aluOp       = ALUOP_SUB;
                cw.pcWriteCond = 1'b1;
                cw.pcSource    = PCSRC_ALUOUT;
                cw.branchNe    = (opcode == OP_BNE);
            end
            S_IEX: begin
                cw.aluSrcA = 1'b1;
                cw.aluSrcB = SRCB_IMM;
                if (opcode == OP_ORI)
                    cw.aluOp = ALUOP_ORI;
                else if (opcode == OP_ANDI)
                    cw.aluOp = ALUOP_ANDI;
                else
                    cw.aluOp = ALUOP_ADD;
            end
            S_IWB: begin
                cw.regDst   = REGDST_RT;
                cw.memtoReg = MEMTOREG_ALUOUT;
                cw.regWrite = 1'b1;
            end
            S_JUMP: begin
                cw.pcWrite  = 1'b1;
                cw.pcSource = PCSRC_JUMP;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                cw.pcWrite  = 1'b1;
                cw.pcSource = PCSRC_JUMP;
                cw.regWrite = 1'b1;
                cw.regDst   = REGDST_RA;
                cw.memtoReg = MEMTOREG_PC;
            end
`endif
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main multicycle control FSM: state register, next-state logic and reset gating of the control word.
// Define MC_JAL_EN to add the jal instruction (state 12).
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t     state, nextState;
    ctrl_word_t cw, cwGated;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= nextState;
    end

    // Unknown opcodes and any unreachable encoding fall back to FETCH.
    always_comb begin
        nextState = S_FETCH;
        case (state)
            S_FETCH:  nextState = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:               nextState = S_MEMADR;
                    OP_RTYPE:                   nextState = S_REX;
                    OP_BEQ, OP_BNE:             nextState = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:   nextState = S_IEX;
                    OP_J:                       nextState = S_JUMP;
`ifdef MC_JAL_EN
                    OP_JAL:                     nextState = S_JAL;
`endif
                    default:                    nextState = S_FETCH;
                endcase
            end
            S_MEMADR: nextState = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nextState = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nextState = mem_ready ? S_FETCH : S_MEMWR;
            S_REX:    nextState = S_RWB;
            S_IEX:    nextState = S_IWB;
            default:  nextState = S_FETCH;
        endcase
    end

    ctrl_word_decode u_decode (
        .state     (state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .cw        (cw)
    );

    // Reset kills every strobe combinationally so an abandoned instruction cannot write anything.
    assign cwGated     = reset ? '0 : cw;

    assign PCWrite     = cwGated.pcWrite;
    assign PCWriteCond = cwGated.pcWriteCond;
    assign BranchNe    = cwGated.branchNe;
    assign IorD        = cwGated.iorD;
    assign MemRead     = cwGated.memRead;
    assign MemWrite    = cwGated.memWrite;
    assign IRWrite     = cwGated.irWrite;
    assign RegDst      = cwGated.regDst;
    assign MemtoReg    = cwGated.memtoReg;
    assign RegWrite    = cwGated.regWrite;
    assign ALUSrcA     = cwGated.aluSrcA;
    assign ALUSrcB     = cwGated.aluSrcB;
    assign PCSource    = cwGated.pcSource;
    assign ALUop       = cwGated.aluOp;
    assign illegal_op  = cwGated.illegalOp;
    assign state_dbg   = state;

endmodule
